// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer.
package whack_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SHOW,
        GAP,
        OVER
    } round_state_t;

    localparam int SEG_COUNT = 7;
    localparam int SCORE_W   = 8;
    localparam int LEVEL_W   = 3;

    // The LFSR yields 0..7 but only seven segments exist; fold the extra code onto 0.
    function automatic logic [2:0] map_seg(input logic [2:0] raw);
        return (32'(raw) >= SEG_COUNT) ? 3'd0 : raw;
    endfunction

    function automatic logic [2:0] next_seg(input logic [2:0] seg);
        return (32'(seg) + 32'd1 >= SEG_COUNT) ? 3'd0 : seg + 3'd1;
    endfunction

endpackage

// File: rtl/penalty_lockout.sv
// Wrong-press lockout: a mask register held for LOCK_CYCLES after a trigger,
// with a clear and a force-all-locked override for game start/end.
module penalty_lockout #(
    parameter int unsigned LOCK_CYCLES = 10,
    parameter int unsigned CNT_W       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       force_all_i,
    input  logic       trig_i,
    input  logic [7:0] mask_i,
    output logic [7:0] lockout_o,
    output logic       idle_o
);

    logic [CNT_W-1:0] timer_q, timer_d;
    logic [7:0]       mask_q, mask_d;

    always_comb begin
        timer_d = timer_q;
        mask_d  = mask_q;
        // The mask drops only when the timer expires, so a forced mask with an idle timer persists.
        if (timer_q != '0) begin
            timer_d = timer_q - CNT_W'(1);
            if (timer_q == CNT_W'(1)) begin
                mask_d = '0;
            end
        end
        if (clear_i) begin
            timer_d = '0;
            mask_d  = '0;
        end else if (force_all_i) begin
            timer_d = '0;
            mask_d  = 8'hFF;
        end else if (trig_i) begin
            timer_d = CNT_W'(LOCK_CYCLES);
            mask_d  = mask_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            mask_q  <= '0;
        end else begin
            timer_q <= timer_d;
            mask_q  <= mask_d;
        end
    end

    assign lockout_o = mask_q;
    assign idle_o    = (timer_q == '0);

endmodule

// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round sequencer: picks moles, grades presses, tracks score/miss/level.
// Optional NO_REPEAT_EN macro: bump a repeated mole segment to the next one.
module mole_round_scheduler
    import whack_pkg::*;
#(
    parameter int unsigned WINDOW_BASE    = 1000,
    parameter int unsigned WINDOW_STEP    = 100,
    parameter int unsigned WINDOW_MIN     = 200,
    parameter int unsigned GAP_CYCLES     = 50,
    parameter int unsigned LOCK_CYCLES    = 10,
    parameter int unsigned HITS_PER_LEVEL = 4,
    parameter int unsigned MAX_LEVEL      = 7,
    parameter int unsigned CNT_W          = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               game_end_i,
    input  logic [2:0]         rand_seg_i,
    input  logic [7:0]         btn_i,
    output logic               mole_valid_o,
    output logic [2:0]         mole_seg_o,
    output logic [7:0]         lockout_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [SCORE_W-1:0] miss_o,
    output logic [LEVEL_W-1:0] level_o,
    output logic               running_o
);

    localparam int STREAK_W = 8;

    round_state_t        state_q, state_d;
    logic [7:0]          btn_q;
    logic                start_q;
    logic [2:0]          seg_q, seg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [SCORE_W-1:0]  miss_q, miss_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic [7:0] press;
    logic       start_edge;
    logic [7:0] mole_bit;
    logic [7:0] wrong;
    logic       hit;
    logic [2:0] seg_pick;
    logic       lock_clear, lock_force, lock_trig, lock_idle;

    function automatic logic [CNT_W-1:0] window_len(input logic [LEVEL_W-1:0] lvl);
        int unsigned dec;
        dec = 32'(lvl) * WINDOW_STEP;
        if (dec >= WINDOW_BASE || (WINDOW_BASE - dec) < WINDOW_MIN) begin
            return CNT_W'(WINDOW_MIN);
        end
        return CNT_W'(WINDOW_BASE - dec);
    endfunction

    assign press      = btn_i & ~btn_q;
    assign start_edge = start_i & ~start_q;
    assign mole_bit   = 8'd1 << seg_q;
    assign hit        = press[seg_q] & ~lockout_o[seg_q];
    assign wrong      = press & ~lockout_o & ~mole_bit;

`ifdef NO_REPEAT_EN
    assign seg_pick = (map_seg(rand_seg_i) == seg_q) ? next_seg(map_seg(rand_seg_i))
                                                     : map_seg(rand_seg_i);
`else
    assign seg_pick = map_seg(rand_seg_i);
`endif

    always_comb begin
        state_d    = state_q;
        seg_d      = seg_q;
        cnt_d      = cnt_q;
        score_d    = score_q;
        miss_d     = miss_q;
        level_d    = level_q;
        streak_d   = streak_q;
        lock_clear = 1'b0;
        lock_force = 1'b0;
        lock_trig  = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                if (start_edge) begin
                    score_d    = '0;
                    miss_d     = '0;
                    level_d    = '0;
                    streak_d   = '0;
                    lock_clear = 1'b1;
                    state_d    = ARM;
                end
            end
            ARM, SHOW, GAP: begin
                // Game end outranks any grading in the same cycle; counters freeze from here.
                if (game_end_i) begin
                    lock_force = 1'b1;
                    state_d    = OVER;
                end else if (state_q == ARM) begin
                    seg_d   = seg_pick;
                    cnt_d   = window_len(level_q);
                    state_d = SHOW;
                end else if (state_q == SHOW) begin
                    if (hit) begin
                        if (score_q != '1) score_d = score_q + SCORE_W'(1);
                        if (32'(streak_q) + 32'd1 >= HITS_PER_LEVEL) begin
                            streak_d = '0;
                            if (32'(level_q) < MAX_LEVEL) level_d = level_q + LEVEL_W'(1);
                        end else begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                        cnt_d   = CNT_W'(GAP_CYCLES);
                        state_d = GAP;
                    end else if (cnt_q == CNT_W'(1)) begin
                        if (miss_q != '1) miss_d = miss_q + SCORE_W'(1);
                        streak_d = '0;
                        if (level_q != '0) level_d = level_q - LEVEL_W'(1);
                        cnt_d   = CNT_W'(GAP_CYCLES);
                        state_d = GAP;
                    end else begin
                        cnt_d     = cnt_q - CNT_W'(1);
                        lock_trig = (wrong != '0) && lock_idle;
                    end
                end else begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ARM;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            btn_q    <= '0;
            start_q  <= 1'b0;
            seg_q    <= '0;
            cnt_q    <= '0;
            score_q  <= '0;
            miss_q   <= '0;
            level_q  <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            btn_q    <= btn_i;
            start_q  <= start_i;
            seg_q    <= seg_d;
            cnt_q    <= cnt_d;
            score_q  <= score_d;
            miss_q   <= miss_d;
            level_q  <= level_d;
            streak_q <= streak_d;
        end
    end

    penalty_lockout #(
        .LOCK_CYCLES(LOCK_CYCLES),
        .CNT_W      (CNT_W)
    ) u_lockout (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (lock_clear),
        .force_all_i(lock_force),
        .trig_i     (lock_trig),
        .mask_i     (wrong),
        .lockout_o  (lockout_o),
        .idle_o     (lock_idle)
    );

    assign mole_valid_o = (state_q == SHOW);
    assign mole_seg_o   = seg_q;
    assign score_o      = score_q;
    assign miss_o       = miss_q;
    assign level_o      = level_q;
    assign running_o    = (state_q == ARM) || (state_q == SHOW) || (state_q == GAP);

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Directed plus randomized check of mole_round_scheduler against a game-rule model.
module tb_mole_round_scheduler;

    localparam int W_BASE = 1000, W_STEP = 100, W_MIN = 200, GAP_N = 50;
    localparam int LOCK_N = 10, HITS_LVL = 4, LVL_MAX = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       game_end_i = 1'b0;
    logic [2:0] rand_seg_i = 3'd0;
    logic [7:0] btn_i = 8'd0;
    logic       mole_valid_o;
    logic [2:0] mole_seg_o;
    logic [7:0] lockout_o;
    logic [7:0] score_o, miss_o;
    logic [2:0] level_o;
    logic       running_o;

    int total = 0;
    int bad = 0;

    mole_round_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .game_end_i  (game_end_i),
        .rand_seg_i  (rand_seg_i),
        .btn_i       (btn_i),
        .mole_valid_o(mole_valid_o),
        .mole_seg_o  (mole_seg_o),
        .lockout_o   (lockout_o),
        .score_o     (score_o),
        .miss_o      (miss_o),
        .level_o     (level_o),
        .running_o   (running_o)
    );

    always #5 clk = ~clk;

    // Game-rule model: phase name plus "cycles left in this phase".
    typedef enum int {P_IDLE, P_ARM, P_SHOW, P_GAP, P_OVER} phase_t;
    phase_t     m_phase = P_IDLE;
    int         m_left = 0, m_score = 0, m_miss = 0, m_level = 0, m_streak = 0;
    int         m_seg = 0, m_ltmr = 0;
    logic [7:0] m_lmask = 8'd0, m_bprev = 8'd0;
    logic       m_sprev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [7:0] press, wrong, lock_old;
        logic       sedge, lock_idle;
        int         pick, win;
        if (rst) begin
            m_phase = P_IDLE; m_left = 0; m_score = 0; m_miss = 0; m_level = 0;
            m_streak = 0; m_seg = 0; m_ltmr = 0; m_lmask = 0; m_bprev = 0; m_sprev = 0;
            return;
        end
        press = btn_i & ~m_bprev;
        sedge = start_i & ~m_sprev;
        m_bprev = btn_i;
        m_sprev = start_i;
        lock_old  = m_lmask;
        lock_idle = (m_ltmr == 0);
        if (m_ltmr > 0) begin
            m_ltmr--;
            if (m_ltmr == 0) m_lmask = 8'd0;
        end
        if (m_phase == P_IDLE || m_phase == P_OVER) begin
            if (sedge) begin
                m_score = 0; m_miss = 0; m_level = 0; m_streak = 0;
                m_lmask = 0; m_ltmr = 0; m_phase = P_ARM;
            end
        end else if (game_end_i) begin
            m_phase = P_OVER; m_lmask = 8'hFF; m_ltmr = 0;
        end else if (m_phase == P_ARM) begin
            pick = (rand_seg_i == 3'd7) ? 0 : int'(rand_seg_i);
`ifdef NO_REPEAT_EN
            if (pick == m_seg) pick = (pick + 1) % 7;
`endif
            m_seg = pick;
            win = W_BASE - m_level * W_STEP;
            m_left = (win < W_MIN) ? W_MIN : win;
            m_phase = P_SHOW;
        end else if (m_phase == P_SHOW) begin
            if (press[m_seg] && !lock_old[m_seg]) begin
                m_score = (m_score < 255) ? m_score + 1 : 255;
                m_streak++;
                if (m_streak == HITS_LVL) begin
                    m_streak = 0;
                    m_level = (m_level < LVL_MAX) ? m_level + 1 : LVL_MAX;
                end
                m_phase = P_GAP; m_left = GAP_N;
            end else if (m_left == 1) begin
                m_miss = (m_miss < 255) ? m_miss + 1 : 255;
                m_streak = 0;
                m_level = (m_level > 0) ? m_level - 1 : 0;
                m_phase = P_GAP; m_left = GAP_N;
            end else begin
                m_left--;
                wrong = press & ~lock_old & ~(8'd1 << m_seg);
                if (wrong != 0 && lock_idle) begin
                    m_lmask = wrong; m_ltmr = LOCK_N;
                end
            end
        end else begin
            if (m_left <= 1) m_phase = P_ARM;
            else m_left--;
        end
    endtask

    task automatic step();
        logic [31:0] obs, exp;
        @(posedge clk);
        model_update();
        #1;
        obs = {mole_valid_o, mole_seg_o, lockout_o, score_o, miss_o, level_o, running_o};
        exp = {(m_phase == P_SHOW), 3'(m_seg), m_lmask, 8'(m_score), 8'(m_miss), 3'(m_level),
               (m_phase == P_ARM || m_phase == P_SHOW || m_phase == P_GAP)};
        chk("cycle", obs, exp);
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!mole_valid_o && n < limit) begin
            step();
            n++;
        end
        chk("wait_valid", 32'(mole_valid_o), 32'd1);
    endtask

    task automatic hit_mole();
        rand_seg_i = 3'($urandom);
        wait_valid(3000);
        repeat ($urandom_range(0, 4)) step();
        btn_i = 8'd1 << mole_seg_o;
        step();
        btn_i = 8'd0;
    endtask

    task automatic count_show(output int n);
        n = 0;
        while (mole_valid_o && n < 3000) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int saved;
        logic [2:0] exp_seg2;

        repeat (3) step();
        chk("reset_score", 32'(score_o), 32'd0);
        chk("reset_running", 32'(running_o), 32'd0);
        rst = 1'b0;
        step();

        // Hit on the 5th SHOW cycle, then measure gap + arm.
        rand_seg_i = 3'd3;
        start_i = 1'b1; step(); start_i = 1'b0;
        step();
        chk("first_show", 32'({mole_valid_o, mole_seg_o}), 32'({1'b1, 3'd3}));
        repeat (4) step();
        btn_i = 8'h08; step(); btn_i = 8'h00;
        chk("hit_score", 32'(score_o), 32'd1);
        chk("hit_valid_drop", 32'(mole_valid_o), 32'd0);
        n = 0;
        while (!mole_valid_o && n < 500) begin step(); n++; end
        chk("gap_plus_arm_len", 32'(n), 32'(GAP_N + 1));

        // Timeout at level 0.
        count_show(n);
        chk("window_l0", 32'(n), 32'(W_BASE));
        chk("timeout_miss", 32'(miss_o), 32'd1);
        chk("timeout_level", 32'(level_o), 32'd0);

        // Level up and window shrink.
        repeat (HITS_LVL) hit_mole();
        chk("level_up", 32'(level_o), 32'd1);
        wait_valid(3000);
        count_show(n);
        chk("window_l1", 32'(n), 32'(W_BASE - W_STEP));
        repeat (8 * HITS_LVL) hit_mole();
        chk("level_sat", 32'(level_o), 32'(LVL_MAX));
        rand_seg_i = 3'd6;
        wait_valid(3000);
        count_show(n);
        chk("window_l7", 32'(n), 32'd300);

        // Wrong press lockout on seg 5 while the mole sits on seg 2.
        rand_seg_i = 3'd2;
        wait_valid(3000);
        chk("mole_seg2", 32'(mole_seg_o), 32'd2);
        saved = int'(score_o);
        btn_i = 8'h20; step(); btn_i = 8'h00;
        chk("lockout_set", 32'(lockout_o), 32'h20);
        step();
        btn_i = 8'h20; step(); btn_i = 8'h00;
        step();
        btn_i = 8'h04; step(); btn_i = 8'h00;
        chk("hit_during_lockout", 32'(score_o), 32'(saved + 1));
        step();
        chk("lockout_hold", 32'(lockout_o), 32'h20);
        repeat (4) step();
        chk("lockout_last", 32'(lockout_o), 32'h20);
        step();
        chk("lockout_clear", 32'(lockout_o), 32'h00);

        // Game end mid-SHOW, then restart.
        wait_valid(3000);
        repeat (3) step();
        saved = int'(score_o);
        game_end_i = 1'b1; step(); game_end_i = 1'b0;
        chk("over_valid", 32'(mole_valid_o), 32'd0);
        chk("over_lockout", 32'(lockout_o), 32'hFF);
        repeat (5) step();
        chk("over_score_held", 32'(score_o), 32'(saved));
        chk("over_running", 32'(running_o), 32'd0);
        start_i = 1'b1; step(); start_i = 1'b0;
        chk("restart_score", 32'(score_o), 32'd0);
        chk("restart_lockout", 32'(lockout_o), 32'd0);

        // Segment mapping and repeat handling.
        rand_seg_i = 3'd7; step();
        chk("rand7_maps_0", 32'({mole_valid_o, mole_seg_o}), 32'({1'b1, 3'd0}));
        btn_i = 8'h01; step(); btn_i = 8'h00;
        rand_seg_i = 3'd4;
        wait_valid(3000);
        chk("seg4_first", 32'(mole_seg_o), 32'd4);
        btn_i = 8'h10; step(); btn_i = 8'h00;
        wait_valid(3000);
`ifdef NO_REPEAT_EN
        exp_seg2 = 3'd5;
`else
        exp_seg2 = 3'd4;
`endif
        chk("seg4_second", 32'(mole_seg_o), 32'(exp_seg2));

        // Randomized play.
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 14) == 0)
                btn_i = ($urandom_range(0, 1) == 1) ? (8'd1 << mole_seg_o) : 8'($urandom);
            else
                btn_i = 8'd0;
            rand_seg_i = 3'($urandom);
            game_end_i = ($urandom_range(0, 700) == 0);
            if ($urandom_range(0, 40) == 0) start_i = ~start_i;
            rst = ($urandom_range(0, 2000) == 0);
            step();
        end
        rst = 1'b1; btn_i = 8'd0; game_end_i = 1'b0; start_i = 1'b0;
        step();
        chk("final_reset", 32'({running_o, score_o, lockout_o}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
